// File: rtl/heap_sift_stage.sv
`default_nettype none
// ============================================================================
//  Module      : heap_sift_stage
//  Description : One sift-down step of the pipelined top-K min-heap sorter.
//                Reads the two children of a node from the next level's RAM
//                during the read phase. Writes the winner into its own level's
//                RAM during the write phase. Forwards the displaced value one
//                level down. Initialises its own RAM after reset.
//  Revision    : 1.0 - initial release
// ============================================================================
module heap_sift_stage #(
   parameter int                    DATA_WIDTH = 32,
   parameter int                    LEVEL      = 1,
   parameter bit                    IS_LEAF    = 1'b0,
   parameter logic [DATA_WIDTH-1:0] INIT_VALUE = '0,
   localparam int                   IW         = (LEVEL > 1) ? LEVEL : 1
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  phase,
   input  logic                  in_valid,
   input  logic [DATA_WIDTH-1:0] in_value,
   input  logic [IW-1:0]         in_idx,
   output logic [LEVEL:0]        ch_addr_a,
   output logic [LEVEL:0]        ch_addr_b,
   input  logic [DATA_WIDTH-1:0] ch_q_a,
   input  logic [DATA_WIDTH-1:0] ch_q_b,
   output logic                  own_we,
   output logic [IW-1:0]         own_addr,
   output logic [DATA_WIDTH-1:0] own_data,
   output logic                  out_valid,
   output logic [DATA_WIDTH-1:0] out_value,
   output logic [LEVEL:0]        out_idx,
   output logic                  init_done,
   output logic                  err
);

   localparam int            c_CW   = LEVEL + 1;
   localparam logic [IW-1:0] c_LAST = IW'((1 << LEVEL) - 1);

   typedef enum logic [1:0] {
      ST_INIT = 2'd0,
      ST_IDLE = 2'd1,
      ST_HOLD = 2'd2
   } state_t;

   state_t                r_state;
   state_t                w_next_state;
   logic [IW-1:0]         r_cnt;
   logic                  r_init_done;
   logic                  r_err;
   logic [DATA_WIDTH-1:0] r_v;
   logic [IW-1:0]         r_idx;
   logic [DATA_WIDTH-1:0] r_c0;
   logic [DATA_WIDTH-1:0] r_c1;
   logic                  r_out_valid;
   logic [DATA_WIDTH-1:0] r_out_value;
   logic [LEVEL:0]        r_out_idx;

   logic                  w_own_we;
   logic [IW-1:0]         w_own_addr;
   logic [DATA_WIDTH-1:0] w_own_data;
   logic                  w_capture;
   logic                  w_fire;
   logic                  w_forward;
   logic                  w_sel;
   logic [DATA_WIDTH-1:0] w_min;
   logic [LEVEL:0]        w_child_base;
   logic [LEVEL:0]        w_out_idx_next;

   // Smaller child wins; a tie keeps child 0.
   assign w_sel          = (r_c1 < r_c0);
   assign w_min          = w_sel ? r_c1 : r_c0;
   assign w_child_base   = c_CW'(in_idx) << 1;
   assign w_out_idx_next = (c_CW'(r_idx) << 1) | c_CW'(w_sel);

   generate
      if (IS_LEAF) begin : g_leaf
         // Last level has no children: never reads, always keeps the value.
         assign w_forward = 1'b0;
         assign ch_addr_a = '0;
         assign ch_addr_b = '0;
      end else begin : g_node
         // Displace only when the incoming value is strictly larger.
         assign w_forward = (r_v > w_min);
         assign ch_addr_a = phase ? '0 : w_child_base;
         assign ch_addr_b = phase ? '0 : (w_child_base | c_CW'(1));
      end
   endgenerate

   // Next-state and own-RAM write port decode.
   always_comb begin
      w_next_state = r_state;
      w_own_we     = 1'b0;
      w_own_addr   = r_idx;
      w_own_data   = r_v;
      w_capture    = 1'b0;
      w_fire       = 1'b0;
      case (r_state)
         ST_INIT: begin
            w_own_we   = 1'b1;
            w_own_addr = r_cnt;
            w_own_data = INIT_VALUE;
            if (r_cnt == c_LAST) begin
               w_next_state = ST_IDLE;
            end
         end
         ST_IDLE: begin
            if (!phase && in_valid) begin
               w_capture    = 1'b1;
               w_next_state = ST_HOLD;
            end
         end
         ST_HOLD: begin
            if (phase) begin
               w_own_we     = 1'b1;
               w_own_addr   = r_idx;
               w_own_data   = w_forward ? w_min : r_v;
               w_fire       = 1'b1;
               w_next_state = ST_IDLE;
            end
         end
         default: begin
            w_next_state = ST_INIT;
         end
      endcase
   end

   // Control state: FSM, init counter, status flags and forward strobe.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state     <= ST_INIT;
         r_cnt       <= '0;
         r_init_done <= 1'b0;
         r_err       <= 1'b0;
         r_out_valid <= 1'b0;
      end else begin
         r_state     <= w_next_state;
         r_out_valid <= w_fire & w_forward;
         if (r_state == ST_INIT) begin
            r_cnt <= r_cnt + IW'(1);
            if (r_cnt == c_LAST) begin
               r_init_done <= 1'b1;
            end
         end
         if (r_state == ST_HOLD && !phase && in_valid) begin
            r_err <= 1'b1;
         end
      end
   end

   // Operand capture in the read phase and forwarded-op payload.
   always_ff @(posedge clk) begin
      if (w_capture) begin
         r_v   <= in_value;
         r_idx <= in_idx;
         r_c0  <= ch_q_a;
         r_c1  <= ch_q_b;
      end
      if (w_fire && w_forward) begin
         r_out_value <= r_v;
         r_out_idx   <= w_out_idx_next;
      end
   end

   // A pending write is suppressed while reset is held.
   assign own_we    = w_own_we & ~rst;
   assign own_addr  = w_own_addr;
   assign own_data  = w_own_data;
   assign out_valid = r_out_valid;
   assign out_value = r_out_value;
   assign out_idx   = r_out_idx;
   assign init_done = r_init_done;
   assign err       = r_err;

endmodule
`default_nettype wire

// File: doc/heap_sift_stage.md
Name: heap_sift_stage

Overview:
- One pipeline stage of the continuous-input top-K min-heap sorter: performs one sift-down step at tree level LEVEL.
- Sits between the level-LEVEL and level-LEVEL+1 dual-port RAMs. Reads the two child nodes from the level-LEVEL+1 RAM, writes the winner into its own level-LEVEL RAM, and forwards the displaced value to the stage for LEVEL+1.
- A global phase signal splits every 2-cycle period into a read phase and a write phase, so each level RAM is read only by its parent stage and written only by its owning stage.
- After reset the stage initialises its own RAM.

Parameters:
- DATA_WIDTH, 32, key width; unsigned compare.
- LEVEL, 1, tree level served; own RAM holds 2^LEVEL nodes.
- IS_LEAF, 0, 1 = last level: no child reads, always writes.
- INIT_VALUE, 0, value written to every own node during init.
- IW (derived), max(LEVEL,1), own index width.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- phase  in  1  global phase: 0 = read phase, 1 = write phase; toggles every cycle.
- in_valid  in  1  op from upstream stage; sampled only when phase=0.
- in_value  in  DATA_WIDTH  value being sifted.
- in_idx  in  IW  node index within this level.
- ch_addr_a  out  LEVEL+1  child RAM port-a address = {idx,0}.
- ch_addr_b  out  LEVEL+1  child RAM port-b address = {idx,1}.
- ch_q_a  in  DATA_WIDTH  child RAM port-a read data (combinational).
- ch_q_b  in  DATA_WIDTH  child RAM port-b read data (combinational).
- own_we  out  1  own-level RAM write enable.
- own_addr  out  IW  own-level RAM address.
- own_data  out  DATA_WIDTH  own-level RAM write data.
- out_valid  out  1  op to next stage.
- out_value  out  DATA_WIDTH  value forwarded down.
- out_idx  out  LEVEL+1  child index for next stage.
- init_done  out  1  own RAM initialised.
- err  out  1  sticky protocol-violation flag.

Behaviour:
- Reset values: out_valid=0, own_we=0, init_done=0, err=0, state=INIT, init counter=0. rst in any state aborts the pending op (no write, no out_valid) and restarts INIT.
- States: INIT, IDLE, HOLD.
- INIT:
  - Each cycle: own_we=1, own_addr=counter, own_data=INIT_VALUE; counter increments.
  - After address 2^LEVEL-1 is written: init_done=1 the next cycle, go to IDLE.
  - in_valid is ignored in INIT.
- IDLE:
  - ch_addr_a/b are driven combinationally from in_idx whenever phase=0.
  - If phase=0 and in_valid=1: register v=in_value, idx=in_idx, c0=ch_q_a, c1=ch_q_b; go to HOLD.
  - in_valid while phase=1 is ignored and does not set err.
- HOLD:
  - Waits for phase=1; stays in HOLD while phase=0.
  - in_valid=1 with phase=0 in HOLD sets err=1 (sticky until rst); the new op is dropped.
  - In the phase=1 cycle:
    - Compute m = min(c0,c1), sel = (c1<c0); a tie selects child 0.
    - If IS_LEAF=1 or v<=m: own_we=1, own_addr=idx, own_data=v; nothing is forwarded.
    - Else: own_we=1, own_addr=idx, own_data=m; out_valid, out_value=v and out_idx={idx,sel} are registered.
    - Return to IDLE.
  - HOLD and the write for an op complete within a single phase=0/phase=1 period.
- Write outputs are combinational and asserted only in the phase=1 cycle of HOLD (or in INIT).
- out_valid is high for exactly the one cycle after the write cycle, i.e. the next stage's phase=0 cycle.
- Issue rule (upstream responsibility): new root ops at most one every 2 periods (4 cycles). Under this rule the read of level L+1 never races the write of level L+1.
- IS_LEAF=1: ch_addr_a/b driven 0; ch_q inputs ignored; out_valid is never asserted.

Test Plan (LEVEL=1, DATA_WIDTH=8, INIT_VALUE=0 unless stated):
- Reset 2 cycles, release -> own_we=1 with addr 0 then 1, data 0; init_done=1 on the third cycle; out_valid stays 0.
- phase=0, in_valid, v=5, idx=1, ch_q_a=7, ch_q_b=9 -> ch_addr_a=2, ch_addr_b=3; next cycle own_we=1, addr 1, data 5; out_valid remains 0.
- v=10, idx=1, c0=7, c1=3 -> own write addr 1, data 3; following cycle out_valid=1 for one cycle, out_value=10, out_idx=3.
- Tie: v=8, idx=0, c0=c1=4 -> own_data=4; out_idx=0, out_value=8.
- in_valid during phase=1 in IDLE -> no capture, err=0. Then a second in_valid with phase=0 while in HOLD -> err=1 and stays 1 until rst; the first op completes normally.
- rst asserted during HOLD -> no own_we in the following phase=1 cycle, out_valid=0, INIT re-runs.
- IS_LEAF=1, v=10, c0=c1=0 -> own_data=10, out_valid never 1.
